// File: rtl/dragonfang_floating_point_pkg.sv
// dragonfang_floating_point_pkg: shared FP execution types, mode encodings and reduction FSM states
package dragonfang_floating_point_pkg;

    typedef struct packed {
        logic maximum_mode;
        logic minimum_mode;
        logic bit_mode;
    } execution_vector_t;

    localparam logic ENABLED_32BIT_MODE   = 1'b0;
    localparam logic ENABLED_64BIT_MODE   = 1'b1;
    localparam logic ENABLED_MAXIMUM_MODE = 1'b1;
    localparam logic ENABLED_MINIMUM_MODE = 1'b1;

    localparam logic [63:0] CANONICAL_NAN_64 = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] CANONICAL_NAN_32 = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUMULATE,
        FOLD,
        DONE
    } reduction_state_t;

endpackage

// File: rtl/vector_floating_point_minmax_unit.sv
// vector_floating_point_minmax_unit: combinational IEEE-754 max/min on one double or two packed floats
module vector_floating_point_minmax_unit
    import dragonfang_floating_point_pkg::*;
(
    input  execution_vector_t execution_vector,
    input  logic [63:0]       a,
    input  logic [63:0]       b,
    output logic [63:0]       result
);

    // Sign-magnitude ordering; -0 sorts below +0
    function automatic logic less_64(input logic [63:0] x, input logic [63:0] y);
        return (x[63] != y[63]) ? x[63] : (x[63] ? x[62:0] > y[62:0] : x[62:0] < y[62:0]);
    endfunction

    function automatic logic less_32(input logic [31:0] x, input logic [31:0] y);
        return (x[31] != y[31]) ? x[31] : (x[31] ? x[30:0] > y[30:0] : x[30:0] < y[30:0]);
    endfunction

    function automatic logic is_nan_64(input logic [63:0] x);
        return &x[62:52] && |x[51:0];
    endfunction

    function automatic logic is_nan_32(input logic [31:0] x);
        return &x[30:23] && |x[22:0];
    endfunction

    // A single NaN operand yields the other operand; two NaNs yield the canonical NaN
    function automatic logic [63:0] pick(
        input logic        want_max,
        input logic        x_nan,
        input logic        y_nan,
        input logic        x_less,
        input logic [63:0] x,
        input logic [63:0] y,
        input logic [63:0] qnan
    );
        return (x_nan && y_nan) ? qnan :
               x_nan            ? y :
               y_nan            ? x :
               want_max         ? (x_less ? y : x) :
                                  (x_less ? x : y);
    endfunction

    logic        want_max;
    logic        enabled;
    logic        wide;
    logic [63:0] res_64;
    logic [63:0] res_lo;
    logic [63:0] res_hi;

    assign want_max = execution_vector.maximum_mode == ENABLED_MAXIMUM_MODE;
    assign enabled  = want_max || execution_vector.minimum_mode == ENABLED_MINIMUM_MODE;
    assign wide     = execution_vector.bit_mode == ENABLED_64BIT_MODE;

    assign res_64 = pick(want_max, is_nan_64(a), is_nan_64(b), less_64(a, b), a, b, CANONICAL_NAN_64);
    assign res_lo = pick(want_max, is_nan_32(a[31:0]), is_nan_32(b[31:0]), less_32(a[31:0], b[31:0]),
                         {32'b0, a[31:0]}, {32'b0, b[31:0]}, {32'b0, CANONICAL_NAN_32});
    assign res_hi = pick(want_max, is_nan_32(a[63:32]), is_nan_32(b[63:32]), less_32(a[63:32], b[63:32]),
                         {32'b0, a[63:32]}, {32'b0, b[63:32]}, {32'b0, CANONICAL_NAN_32});

    assign result = !enabled ? '0 : wide ? res_64 : {res_hi[31:0], res_lo[31:0]};

endmodule

// File: rtl/vector_floating_point_reduction_unit.sv
// vector_floating_point_reduction_unit: folds a stream of 64-bit beats plus a scalar seed
// into one max/min result using the shared min/max unit as its only comparator.
module vector_floating_point_reduction_unit
    import dragonfang_floating_point_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  execution_vector_t execution_vector,
    input  logic [63:0]       vs1,
    input  logic [63:0]       vs2,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [63:0]       vd,
    output logic              out_valid,
    input  logic              out_ready
);

    reduction_state_t  state_q, state_d;
    execution_vector_t op_q, op_d, mm_op;
    logic [63:0]       acc_q, acc_d, op_a, op_b, mm_result;
    logic              idle, fold, narrow, accept;

    assign idle     = state_q == IDLE;
    assign fold     = state_q == FOLD;
    assign mm_op    = idle ? execution_vector : op_q;
    assign narrow   = mm_op.bit_mode == ENABLED_32BIT_MODE;
    assign in_ready = idle || state_q == ACCUMULATE;
    assign accept   = in_valid && in_ready;

    // First-beat seed carries vs2's upper lane so lane 1 reduces against itself
    assign op_a = idle ? (narrow ? {vs2[63:32], vs1[31:0]} : vs1) :
                  fold ? {32'b0, acc_q[63:32]} : acc_q;
    assign op_b = fold ? {32'b0, acc_q[31:0]} : vs2;

    assign out_valid = state_q == DONE;
    assign vd        = !out_valid ? '0 : narrow ? {32'b0, acc_q[31:0]} : acc_q;

    vector_floating_point_minmax_unit u_minmax (
        .execution_vector (mm_op),
        .a                (op_a),
        .b                (op_b),
        .result           (mm_result)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        case (state_q)
            IDLE, ACCUMULATE: if (accept) begin
                acc_d   = mm_result;
                op_d    = mm_op;
                state_d = in_last ? (narrow ? FOLD : DONE) : ACCUMULATE;
            end
            FOLD: begin
                acc_d   = {32'b0, mm_result[31:0]};
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
        end
    end

endmodule
